pc_btb: RTL and testbench
=========================

// Module: pc_btb
// PURPOSE
//  Fetch-stage program counter generator with a direct-mapped branch target buffer (BTB).
//  Each cycle it selects the next PC from four sources, highest priority first:
//  trap redirect, execute-stage correction, BTB prediction, sequential PC+4.
//  It drives the fetch address and the prediction tag that travels down the pipe.
//  Execute uses that tag to detect a mispredict and train the BTB.
// PARAMETERS
//  XLEN          32   address / data width
//  RESET_VECTOR  '0   PC value loaded on reset; bits [1:0] are forced to 0
//  BTB_ENTRIES   16   number of BTB entries; power of two, >= 2
// PORTS
//  clk          in   1     clock; all state updates on its rising edge
//  rst_n        in   1     synchronous active-low reset
//  stall        in   1     hold the current PC (fetch bubble)
//  trap_valid   in   1     redirect to trap_target (highest priority)
//  trap_target  in   XLEN  trap/exception handler address
//  pcsrc        in   1     execute-stage redirect: mispredict or jump correction
//  pctarget     in   XLEN  corrected target from execute
//  upd_valid    in   1     BTB update strobe from execute (one resolved control transfer)
//  upd_pc       in   XLEN  PC of the resolved branch/jump
//  upd_target   in   XLEN  resolved target address
//  upd_taken    in   1     1 = branch was taken
//  pc           out  XLEN  current fetch PC
//  pcplus4      out  XLEN  pc + 4, modulo 2^XLEN
//  pred_taken   out  1     BTB hit on the current pc
//  pred_target  out  XLEN  BTB target for the current pc; 0 when pred_taken = 0
// BEHAVIOUR
//  Reset (rst_n = 0 at a clock edge):
//   - pc <= RESET_VECTOR with bits [1:0] cleared; all BTB valid bits cleared.
//   - All other inputs, including upd_valid, trap_valid and pcsrc, are ignored during reset.
//   - Reset in mid-operation discards pending state; no BTB write occurs in that cycle.
//  Next-PC selection at each edge (rst_n = 1):
//   - trap_valid              -> trap_target
//   - else pcsrc              -> pctarget
//   - else stall              -> pc (hold)
//   - else pred_taken         -> pred_target
//   - else                    -> pcplus4
//  Redirect rules:
//   - trap_valid and pcsrc override stall; a redirect is never lost to a stall.
//   - Bits [1:0] of every selected next PC are forced to 00; misaligned targets are truncated, not trapped.
//  Arithmetic: pcplus4 is XLEN bits and wraps silently (0xFFFFFFFC -> 0x00000000).
//  BTB lookup (combinational from pc, zero latency):
//   - IDX = $clog2(BTB_ENTRIES)
//   - index = pc[IDX+1:2], tag = pc[XLEN-1:IDX+2]
//   - hit = valid[index] && tag matches
//  BTB update (at the clock edge, when upd_valid = 1; independent of stall and redirects):
//   - upd_taken = 1: entry[upd_pc index] <= {valid = 1, tag(upd_pc), upd_target & ~3}; overwrites any alias.
//   - upd_taken = 0 and stored tag matches: the entry is invalidated.
//   - upd_taken = 0 and no tag match: the table is unchanged.
//  No write-to-read bypass: a lookup in the same cycle as an update to the same index sees the old entry.
//  Latency: a newly written entry first affects pred_taken in the cycle after the write edge.
// STRUCTURE
//  pc_pkg:
//   - btb_entry_t struct {valid, tag, target}
//   - function btb_idx()
//   - constant PC_ALIGN_MASK
//  Sub-module btb_dm:
//   - direct-mapped table with clk and rst_n
//   - combinational read port, one synchronous write/invalidate port
//   - parameters XLEN and BTB_ENTRIES
//  pc_btb keeps only the PC register, the priority mux and pcplus4.
// TESTING (XLEN = 32, BTB_ENTRIES = 16)
//  1. RESET_VECTOR = 0x1000; rst_n low for 2 cycles, then high.
//     -> pc = 0x1000, then 0x1004, 0x1008; pred_taken = 0 throughout.
//  2. stall high for 3 cycles at pc = 0x1008.
//     -> pc stays 0x1008; the cycle after release pc = 0x100C.
//  3. upd_valid = 1, upd_pc = 0x1010, upd_target = 0x2000, upd_taken = 1; later run sequentially to 0x1010.
//     -> at pc = 0x1010: pred_taken = 1, pred_target = 0x2000; next pc = 0x2000.
//  4. Same edge: trap_valid = 1 (0x8000), pcsrc = 1 (0x3000), stall = 1.
//     -> next pc = 0x8000.
//     Then pcsrc = 1 alone with pctarget = 0x3003.
//     -> next pc = 0x3000.
//  5. After test 3, fetch alias pc 0x1050 -> pred_taken = 0 (tag mismatch).
//     Then upd_pc = 0x1010, upd_taken = 0 -> next visit to 0x1010 gives pred_taken = 0 and pc -> 0x1014.
//  6. RESET_VECTOR = 0xFFFFFFFC -> pc 0xFFFFFFFC then 0x00000000.
//     Assert rst_n = 0 mid-run with upd_valid = 1 -> BTB remains empty after reset.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch PC generator and its branch target buffer.
// The BTB entry layout is sized from the constants below, so instances of
// pc_btb / btb_dm are expected to keep XLEN and BTB_ENTRIES at these values.
package pc_pkg;

  localparam int PC_XLEN        = 32;
  localparam int PC_BTB_ENTRIES = 16;
  localparam int PC_IDX_W       = $clog2(PC_BTB_ENTRIES);
  localparam int PC_TAG_W       = PC_XLEN - PC_IDX_W - 2;

  // Clears bits [1:0]; every fetch address and stored target is word aligned.
  localparam logic [PC_XLEN-1:0] PC_ALIGN_MASK = {{(PC_XLEN-2){1'b1}}, 2'b00};

  typedef struct packed {
    logic                valid;
    logic [PC_TAG_W-1:0] tag;
    logic [PC_XLEN-1:0]  target;
  } btb_entry_t;

  // Table index: the word-address bits just above the byte offset.
  function automatic logic [PC_IDX_W-1:0] btb_idx(input logic [PC_XLEN-1:0] pc);
    return PC_IDX_W'(pc >> 2);
  endfunction

  // Tag: everything above the index bits.
  function automatic logic [PC_TAG_W-1:0] btb_tag(input logic [PC_XLEN-1:0] pc);
    return PC_TAG_W'(pc >> (PC_IDX_W + 2));
  endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer: one combinational lookup port and one
// synchronous write/invalidate port. Lookups never see a same-cycle write.
module btb_dm
  import pc_pkg::*;
#(
  parameter int XLEN        = PC_XLEN,
  parameter int BTB_ENTRIES = PC_BTB_ENTRIES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rd_pc_i,
  output logic            rd_hit_o,
  output logic [XLEN-1:0] rd_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i
);

  btb_entry_t          table_q [BTB_ENTRIES];
  btb_entry_t          rd_entry;
  logic [PC_IDX_W-1:0] rd_idx;
  logic [PC_TAG_W-1:0] rd_tag;
  logic [PC_IDX_W-1:0] upd_idx;
  logic [PC_TAG_W-1:0] upd_tag;
  logic                upd_match;

  // Lookup: hit only when the indexed entry is valid and its tag matches.
  always_comb begin
    rd_idx      = btb_idx(rd_pc_i);
    rd_tag      = btb_tag(rd_pc_i);
    rd_entry    = table_q[rd_idx];
    rd_hit_o    = rd_entry.valid && (rd_entry.tag == rd_tag);
    rd_target_o = rd_hit_o ? rd_entry.target : '0;
  end

  // Update side: locate the entry for the resolved branch and compare its tag.
  always_comb begin
    upd_idx   = btb_idx(upd_pc_i);
    upd_tag   = btb_tag(upd_pc_i);
    upd_match = (table_q[upd_idx].tag == upd_tag);
  end

  // Reset clears only valid bits; taken installs (overwriting aliases), not-taken evicts a matching entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
      end
    end else if (upd_valid_i) begin
      if (upd_taken_i) begin
        table_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target_i & PC_ALIGN_MASK};
      end else if (upd_match) begin
        table_q[upd_idx].valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_btb.sv
// Fetch-stage PC generator: trap > execute correction > stall > BTB prediction > PC+4.
module pc_btb
  import pc_pkg::*;
#(
  parameter int              XLEN         = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_ENTRIES  = PC_BTB_ENTRIES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            pcsrc,
  input  logic [XLEN-1:0] pctarget,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus4,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_sel;

  btb_dm #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_pc_i      (pc_q),
    .rd_hit_o     (pred_taken),
    .rd_target_o  (pred_target),
    .upd_valid_i  (upd_valid),
    .upd_pc_i     (upd_pc),
    .upd_target_i (upd_target),
    .upd_taken_i  (upd_taken)
  );

  assign pc      = pc_q;
  assign pcplus4 = pc_q + {{(XLEN-3){1'b0}}, 3'b100};

  // Priority next-PC mux; redirects win over stall so they are never dropped.
  always_comb begin
    if (trap_valid) begin
      pc_sel = trap_target;
    end else if (pcsrc) begin
      pc_sel = pctarget;
    end else if (stall) begin
      pc_sel = pc_q;
    end else if (pred_taken) begin
      pc_sel = pred_target;
    end else begin
      pc_sel = pcplus4;
    end
    pc_d = pc_sel & PC_ALIGN_MASK;
  end

  // PC register; misaligned reset vectors are truncated to a word boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR & PC_ALIGN_MASK;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_btb.sv
// Self-checking bench for pc_btb: directed vector table, randomized run against
// a behavioural model, and hand-written reset/wrap sequences.
module tb_pc_btb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        trapValid;
  logic [31:0] trapTarget;
  logic        pcsrc;
  logic [31:0] pcTarget;
  logic        updValid;
  logic [31:0] updPc;
  logic [31:0] updTarget;
  logic        updTaken;

  logic [31:0] pcA, pcPlus4A, predTargetA;
  logic        predTakenA;
  logic [31:0] pcB, pcPlus4B, predTargetB;
  logic        predTakenB;

  int checks = 0;
  int errors = 0;

  // Model: per-index record of the last installed branch (word address + target).
  logic [31:0] mPcA, mPcB;
  bit          mValid [16];
  logic [31:0] mWord  [16];
  logic [31:0] mTgt   [16];

  typedef struct {
    logic        stall;
    logic        trapValid;
    logic [31:0] trapTarget;
    logic        pcsrc;
    logic [31:0] pcTarget;
    logic        updValid;
    logic [31:0] updPc;
    logic [31:0] updTarget;
    logic        updTaken;
    logic [31:0] expPc;
    logic        expPred;
    logic [31:0] expTgt;
  } vec_t;

  vec_t vecs[$];

  pc_btb #(.XLEN(32), .RESET_VECTOR(32'h0000_1000), .BTB_ENTRIES(16)) dutA (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .trap_valid(trapValid), .trap_target(trapTarget),
    .pcsrc(pcsrc), .pctarget(pcTarget),
    .upd_valid(updValid), .upd_pc(updPc), .upd_target(updTarget), .upd_taken(updTaken),
    .pc(pcA), .pcplus4(pcPlus4A), .pred_taken(predTakenA), .pred_target(predTargetA)
  );

  pc_btb #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC), .BTB_ENTRIES(16)) dutB (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .trap_valid(trapValid), .trap_target(trapTarget),
    .pcsrc(pcsrc), .pctarget(pcTarget),
    .upd_valid(updValid), .upd_pc(updPc), .upd_target(updTarget), .upd_taken(updTaken),
    .pc(pcB), .pcplus4(pcPlus4B), .pred_taken(predTakenB), .pred_target(predTargetB)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int modelIdx(logic [31:0] a);
    return int'((a >> 2) % 32'd16);
  endfunction

  function automatic bit modelHit(logic [31:0] a);
    int i = modelIdx(a);
    return mValid[i] && (mWord[i] == (a >> 2));
  endfunction

  function automatic logic [31:0] modelTarget(logic [31:0] a);
    return modelHit(a) ? mTgt[modelIdx(a)] : 32'h0;
  endfunction

  function automatic logic [31:0] modelNext(logic [31:0] a);
    logic [31:0] n;
    if (trapValid)        n = trapTarget;
    else if (pcsrc)       n = pcTarget;
    else if (stall)       n = a;
    else if (modelHit(a)) n = modelTarget(a);
    else                  n = a + 32'd4;
    return n & 32'hFFFF_FFFC;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic modelEdge();
    logic [31:0] nA, nB;
    int i;
    if (!rst_n) begin
      mPcA = 32'h0000_1000;
      mPcB = 32'hFFFF_FFFC;
      for (int k = 0; k < 16; k++) mValid[k] = 1'b0;
    end else begin
      nA = modelNext(mPcA);
      nB = modelNext(mPcB);
      if (updValid) begin
        i = modelIdx(updPc);
        if (updTaken) begin
          mValid[i] = 1'b1;
          mWord[i]  = updPc >> 2;
          mTgt[i]   = updTarget & 32'hFFFF_FFFC;
        end else if (mWord[i] == (updPc >> 2)) begin
          mValid[i] = 1'b0;
        end
      end
      mPcA = nA;
      mPcB = nB;
    end
  endtask

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic checkModel();
    checkOutput("mdlPcA",      pcA,             mPcA);
    checkOutput("mdlPlus4A",   pcPlus4A,        mPcA + 32'd4);
    checkOutput("mdlPredA",    32'(predTakenA), 32'(modelHit(mPcA)));
    checkOutput("mdlTgtA",     predTargetA,     modelTarget(mPcA));
    checkOutput("mdlPcB",      pcB,             mPcB);
    checkOutput("mdlPlus4B",   pcPlus4B,        mPcB + 32'd4);
    checkOutput("mdlPredB",    32'(predTakenB), 32'(modelHit(mPcB)));
    checkOutput("mdlTgtB",     predTargetB,     modelTarget(mPcB));
  endtask

  task automatic applyStimulus(vec_t v);
    stall      = v.stall;
    trapValid  = v.trapValid;
    trapTarget = v.trapTarget;
    pcsrc      = v.pcsrc;
    pcTarget   = v.pcTarget;
    updValid   = v.updValid;
    updPc      = v.updPc;
    updTarget  = v.updTarget;
    updTaken   = v.updTaken;
  endtask

  // One cycle: compare against the model away from the edge, then clock both.
  task automatic cycle();
    checkModel();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  function automatic vec_t mk(logic st, logic tv, logic [31:0] tt, logic ps, logic [31:0] pt,
                              logic uv, logic [31:0] up, logic [31:0] ut, logic uk,
                              logic [31:0] ePc, logic ePred, logic [31:0] eTgt);
    vec_t v;
    v.stall = st; v.trapValid = tv; v.trapTarget = tt; v.pcsrc = ps; v.pcTarget = pt;
    v.updValid = uv; v.updPc = up; v.updTarget = ut; v.updTaken = uk;
    v.expPc = ePc; v.expPred = ePred; v.expTgt = eTgt;
    return v;
  endfunction

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed rows: inputs for the cycle and the expected outputs of dutA before its edge.
    vecs.push_back(mk(0,0,0,        0,0,        0,0,0,0,                   32'h1000,0,0));
    vecs.push_back(mk(0,0,0,        0,0,        0,0,0,0,                   32'h1004,0,0));
    vecs.push_back(mk(1,0,0,        0,0,        0,0,0,0,                   32'h1008,0,0));
    vecs.push_back(mk(1,0,0,        0,0,        0,0,0,0,                   32'h1008,0,0));
    vecs.push_back(mk(1,0,0,        0,0,        0,0,0,0,                   32'h1008,0,0));
    vecs.push_back(mk(0,0,0,        0,0,        0,0,0,0,                   32'h1008,0,0));
    vecs.push_back(mk(0,0,0,        0,0,        1,32'h1010,32'h2000,1,     32'h100C,0,0));
    vecs.push_back(mk(0,0,0,        0,0,        0,0,0,0,                   32'h1010,1,32'h2000));
    vecs.push_back(mk(1,1,32'h8000, 1,32'h3000, 0,0,0,0,                   32'h2000,0,0));
    vecs.push_back(mk(0,0,0,        1,32'h3003, 0,0,0,0,                   32'h8000,0,0));
    vecs.push_back(mk(0,0,0,        1,32'h1050, 0,0,0,0,                   32'h3000,0,0));
    vecs.push_back(mk(0,0,0,        1,32'h1010, 1,32'h1010,0,0,            32'h1050,0,0));
    vecs.push_back(mk(0,0,0,        0,0,        1,32'h1010,32'h2224,1,     32'h1010,0,0));
    vecs.push_back(mk(0,0,0,        1,32'h1050, 1,32'h1050,32'h4002,1,     32'h1014,0,0));
    vecs.push_back(mk(1,0,0,        0,0,        0,0,0,0,                   32'h1050,1,32'h4000));
    vecs.push_back(mk(0,0,0,        0,0,        0,0,0,0,                   32'h1050,1,32'h4000));
    vecs.push_back(mk(0,0,0,        1,32'h1010, 0,0,0,0,                   32'h4000,0,0));
    vecs.push_back(mk(0,0,0,        1,32'h1050, 1,32'h1010,0,0,            32'h1010,0,0));
    vecs.push_back(mk(0,0,0,        0,0,        0,0,0,0,                   32'h1050,1,32'h4000));
    vecs.push_back(mk(0,0,0,        0,0,        0,0,0,0,                   32'h4000,0,0));

    // Power-on reset held for two edges.
    applyStimulus(idle);
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      modelEdge();
    end
    @(negedge clk);
    rst_n = 1'b1;

    checkOutput("rstPcA",     pcA,      32'h0000_1000);
    checkOutput("rstPredA",   32'(predTakenA), 32'h0);
    checkOutput("rstPcB",     pcB,      32'hFFFF_FFFC);
    checkOutput("wrapPlus4B", pcPlus4B, 32'h0000_0000);

    $display("[TB] directed vector table");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("tblPc%0d", i),   pcA,             vecs[i].expPc);
      checkOutput($sformatf("tblPred%0d", i), 32'(predTakenA), 32'(vecs[i].expPred));
      checkOutput($sformatf("tblTgt%0d", i),  predTargetA,     vecs[i].expTgt);
      cycle();
      if (i == 0) checkOutput("wrapPcB", pcB, 32'h0000_0000);
    end

    $display("[TB] randomized run against model");
    for (int n = 0; n < 400; n++) begin
      stall      = ($urandom_range(0, 3) == 0);
      trapValid  = ($urandom_range(0, 15) == 0);
      trapTarget = 32'h1000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      pcsrc      = ($urandom_range(0, 5) == 0);
      pcTarget   = 32'h1000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      updValid   = ($urandom_range(0, 2) == 0);
      updPc      = 32'h1000 + ($urandom_range(0, 63) << 2);
      updTarget  = 32'h1000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      updTaken   = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("[TB] mid-run reset with pending update and trap");
    applyStimulus(idle);
    updValid   = 1'b1;
    updPc      = 32'h1010;
    updTarget  = 32'h5000;
    updTaken   = 1'b1;
    trapValid  = 1'b1;
    trapTarget = 32'h8000;
    rst_n      = 1'b0;
    cycle();
    rst_n = 1'b1;
    applyStimulus(idle);
    checkOutput("midRstPcA", pcA, 32'h0000_1000);
    checkOutput("midRstPcB", pcB, 32'hFFFF_FFFC);
    pcsrc    = 1'b1;
    pcTarget = 32'h1010;
    cycle();
    applyStimulus(idle);
    checkOutput("midRstPc1010",  pcA,             32'h0000_1010);
    checkOutput("midRstPredA",   32'(predTakenA), 32'h0);
    checkOutput("midRstTgtA",    predTargetA,     32'h0);
    cycle();
    checkOutput("midRstSeqA",    pcA,             32'h0000_1014);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
